// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter.
// Opcodes, flag bundle and datapath width.
package alu_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 4-bit ALU: ADD, SUB, AND, OR with {N,Z,C,V}.
// SUB is a + ~b + 1, so C is the carry-out (1 means no borrow).
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        sel_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    alu_op_e           op;
    alu_flags_t        flg;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;

    assign op = alu_op_e'(sel_i);

    always_comb begin
        b_eff = (op == ALU_SUB) ? ~b_i : b_i;
        sum   = {1'b0, a_i} + {1'b0, b_eff}
              + {{DATA_W{1'b0}}, (op == ALU_SUB)};
        res   = '0;
        flg   = '0;
        unique case (op)
            ALU_ADD, ALU_SUB: begin
                res   = sum[DATA_W-1:0];
                flg.c = sum[DATA_W];
                flg.v = (a_i[DATA_W-1] == b_eff[DATA_W-1])
                      && (res[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_AND: res = a_i & b_i;
            ALU_OR:  res = a_i | b_i;
            default: res = '0;
        endcase
        flg.n = res[DATA_W-1];
        flg.z = (res == '0);
    end

    assign result_o = res;
    assign flags_o  = flg;

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; the winner's result lands
// in a single response register drained by a consumer.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic [7:0] op_count
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic       state_q, state_d;
    logic       last_q, last_d;
    logic       id_q, id_d;
    logic [3:0] res_q, res_d;
    logic [3:0] flg_q, flg_d;
    logic [7:0] cnt_q, cnt_d;

    logic       can_accept;
    logic       gnt0, gnt1;
    logic       accept;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_res, alu_flg;

    // Contention goes to whoever did not win last time.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || rsp_ready;
        gnt0 = req0_valid && (!req1_valid || last_q);
        gnt1 = req1_valid && (!req0_valid || !last_q);
        req0_ready = rst_n && can_accept && gnt0;
        req1_ready = rst_n && can_accept && gnt1;
        accept = req0_ready || req1_ready;
        alu_a   = gnt1 ? req1_a   : req0_a;
        alu_b   = gnt1 ? req1_b   : req0_b;
        alu_sel = gnt1 ? req1_sel : req0_sel;
    end

    alu_arbiter_alu u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .sel_i    (alu_sel),
        .result_o (alu_res),
        .flags_o  (alu_flg)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        res_d   = res_q;
        flg_d   = flg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = ST_FULL;
            last_d  = req1_ready;
            id_d    = req1_ready;
            res_d   = alu_res;
            flg_d   = alu_flg;
            cnt_d   = cnt_q + 8'd1;
        end else if (state_q == ST_FULL && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter.
// Flags are checked as {N,Z,C,V} under a per-vector mask.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [1:0] req0_sel;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [1:0] req1_sel;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_result, rsp_flags;
    logic [7:0] op_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .op_count   (op_count)
    );

    typedef struct {
        logic       id;
        logic [1:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] flg;
        logic [3:0] msk;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drive(input logic id, input logic [1:0] sel,
                         input logic [3:0] a, input logic [3:0] b);
        if (id) begin
            req1_valid = 1'b1;
            req1_sel = sel; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1;
            req0_sel = sel; req0_a = a; req0_b = b;
        end
    endtask

    task automatic chk_rsp(input string name, input logic id,
                           input logic [3:0] res, input logic [3:0] flg,
                           input logic [3:0] msk);
        chk({name, ".valid"}, rsp_valid, 1);
        chk({name, ".id"}, rsp_id, id);
        chk({name, ".result"}, rsp_result, res);
        chk({name, ".flags"}, rsp_flags & msk, flg & msk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [3:0] hold_res, hold_flg;
    logic       hold_id;
    int         bad;

    initial begin
        vecs[0] = '{1'b0, 2'd0, 4'h7, 4'h1, 4'h8, 4'b1001, 4'hF};
        vecs[1] = '{1'b1, 2'd0, 4'h9, 4'h8, 4'h1, 4'b0011, 4'hF};
        vecs[2] = '{1'b0, 2'd1, 4'h5, 4'h5, 4'h0, 4'b0100, 4'b1101};
        vecs[3] = '{1'b1, 2'd3, 4'hA, 4'h5, 4'hF, 4'b1000, 4'hF};
        vecs[4] = '{1'b0, 2'd2, 4'hC, 4'hA, 4'h8, 4'b1000, 4'hF};
        vecs[5] = '{1'b1, 2'd1, 4'h2, 4'h7, 4'hB, 4'b1000, 4'b1101};
        vecs[6] = '{1'b0, 2'd0, 4'h4, 4'h4, 4'h8, 4'b1001, 4'hF};
        vecs[7] = '{1'b1, 2'd0, 4'hF, 4'h1, 4'h0, 4'b0110, 4'hF};

        req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_a = 0; req1_b = 0; req1_sel = 0;
        idle();
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        step();
        chk("rst.valid", rsp_valid, 0);
        chk("rst.id", rsp_id, 0);
        chk("rst.result", rsp_result, 0);
        chk("rst.flags", rsp_flags, 0);
        chk("rst.count", op_count, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst.ready0", req0_ready, 0);
        chk("rst.ready1", req1_ready, 0);
        idle();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            idle();
            drive(vecs[i].id, vecs[i].sel, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d.ready", i),
                vecs[i].id ? req1_ready : req0_ready, 1);
            step();
            chk_rsp($sformatf("v%0d", i), vecs[i].id, vecs[i].res,
                    vecs[i].flg, vecs[i].msk);
            if (i == 0) chk("v0.count", op_count, 1);
        end
        chk("table.count", op_count, 8);

        idle();
        drive(1'b0, 2'd3, 4'h3, 4'h4);
        step();
        chk_rsp("bp.first", 1'b0, 4'h7, 4'b0000, 4'hF);
        hold_id = rsp_id; hold_res = rsp_result; hold_flg = rsp_flags;
        idle();
        drive(1'b1, 2'd0, 4'h9, 4'h8);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d.ready1", i), req1_ready, 0);
            step();
            chk_rsp($sformatf("bp%0d.hold", i), hold_id, hold_res,
                    hold_flg, 4'hF);
        end
        chk("bp.count", op_count, 9);
        rsp_ready = 1'b1;
        #1;
        chk("bp.release.ready1", req1_ready, 1);
        step();
        chk_rsp("bp.new", 1'b1, 4'h1, 4'b0011, 4'b0011);
        chk("bp.count2", op_count, 10);

        idle();
        step();
        chk("drain.valid", rsp_valid, 0);
        step();
        chk("empty.valid", rsp_valid, 0);
        chk("empty.count", op_count, 10);

        do_reset();
        chk("wrap.start", op_count, 0);
        drive(1'b0, 2'd0, 4'h1, 4'h1);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (req0_ready !== 1'b1) bad++;
            step();
            if (i == 254) chk("wrap.255", op_count, 255);
        end
        chk("wrap.stalls", bad, 0);
        chk("wrap.zero", op_count, 0);
        chk("wrap.full", rsp_valid, 1);

        drive(1'b1, 2'd0, 4'h1, 4'h1);
        rst_n = 1'b0;
        #1;
        chk("rstfull.ready0", req0_ready, 0);
        chk("rstfull.ready1", req1_ready, 0);
        step();
        chk("rstfull.valid", rsp_valid, 0);
        chk("rstfull.count", op_count, 0);
        chk("rstfull.result", rsp_result, 0);
        rst_n = 1'b1;

        idle();
        drive(1'b0, 2'd1, 4'h3, 4'h5);
        drive(1'b1, 2'd2, 4'h5, 4'h2);
        #1;
        chk("cont.ready0", req0_ready, 1);
        chk("cont.ready1", req1_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0)
                chk_rsp($sformatf("cont%0d", i), 1'b0, 4'b1110,
                        4'b1000, 4'b1100);
            else
                chk_rsp($sformatf("cont%0d", i), 1'b1, 4'b0000,
                        4'b0100, 4'b1100);
        end
        chk("cont.count", op_count, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-002 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 The block SHALL have port req0_valid, input, 1: requester 0 has an operation.
REQ-004 The block SHALL have port req0_ready, output, 1: requester 0's operation is accepted this cycle.
REQ-005 The block SHALL have ports req0_a and req0_b, input, 4 each: operands for requester 0.
REQ-006 The block SHALL have port req0_sel, input, 2: opcode for requester 0 (0 ADD, 1 SUB, 2 AND, 3 OR).
REQ-007 The block SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_sel, identical to the requester-0 ports but for requester 1.
REQ-008 The block SHALL have port rsp_valid, output, 1: the response register holds a result.
REQ-009 The block SHALL have port rsp_ready, input, 1: the consumer takes the response.
REQ-010 The block SHALL have port rsp_id, output, 1: the requester that owns the response.
REQ-011 The block SHALL have port rsp_result, output, 4: the ALU result.
REQ-012 The block SHALL have port rsp_flags, output, 4: {N,Z,C,V} from the ALU.
REQ-013 The block SHALL have port op_count, output, 8: total operations accepted, wrapping.

Function
REQ-014 The block SHALL time-share one 4-bit ALU instance between the two requesters; the ALU is combinational, with inputs a, b and Sel and outputs Result and N, Z, C, V.
REQ-015 Handshake: a transfer SHALL occur on any edge where valid and ready are both high.
  - Requesters hold a, b and sel stable while valid is high and ready is low.
  - The consumer takes the response on rsp_valid && rsp_ready.
REQ-016 can_accept SHALL be !rsp_valid || rsp_ready, so a full register drains and refills in the same cycle.
REQ-017 At most one of req0_ready and req1_ready SHALL be high in any cycle, and ready SHALL be high only when can_accept is high and that requester's valid is high.
REQ-018 Grant: a requester that is the only one valid SHALL win; when both are valid, the requester that is not last_grant SHALL win.
REQ-019 last_grant SHALL update to the winning requester on every accepted transfer.
REQ-020 FSM: states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready with accept (new data) or on !rsp_ready (data held).
REQ-021 Latency: an operation accepted at edge N SHALL appear on rsp_* from edge N onward; throughput is one operation per cycle.
REQ-022 The ALU SHALL be driven from the granted requester's operands combinationally, and the result and flags SHALL be captured into the response register on accept.
REQ-023 While in FULL with rsp_ready low, rsp_id, rsp_result and rsp_flags SHALL hold stable.
REQ-024 op_count SHALL increment by 1 per accepted transfer and wrap from 255 to 0.
REQ-025 rsp_ready high while in EMPTY SHALL have no effect.
REQ-026 With no valid requester, the response register and last_grant SHALL hold.

Reset
REQ-027 While rst_n is low at a clock edge, the block SHALL force:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, op_count=0;
  - last_grant=1, so requester 0 wins the first contention;
  - FSM to EMPTY.
REQ-028 Reset while in FULL SHALL discard the held response without a transfer.
REQ-029 req0_ready and req1_ready SHALL be low during reset.

Structure
REQ-030 A shared package alu_pkg SHALL hold:
  - opcode enum ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_OR=2'd3;
  - a 4-bit flags struct {N,Z,C,V};
  - constant DATA_W=4.
REQ-031 The existing ALU SHALL be the only sub-module, instantiated once, with the grant logic, FSM and counter inline.

Verification
REQ-032 The bench SHALL cover req0 only, ADD 7+1, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=4'b1000, flags N=1 Z=0 C=0 V=1, op_count=1.
REQ-033 The bench SHALL cover both valid: req0 SUB 3-5 and req1 AND 5&2, held -> first response id=0, result=4'b1110, N=1; second response id=1, result=0, Z=1; then alternation continues 0,1,0,1.
REQ-034 The bench SHALL cover backpressure: rsp_ready=0 for 3 cycles after a response with req1 valid -> req1_ready stays 0 and rsp_* stay stable; when rsp_ready=1, req1 is accepted in that same cycle.
REQ-035 The bench SHALL cover req1 ADD 9+8 -> result=4'b0001 with C=1 and V=1.
REQ-036 The bench SHALL cover 256 back-to-back accepts -> op_count wraps to 0.
REQ-037 The bench SHALL cover rst_n=0 while FULL -> next edge rsp_valid=0 and op_count=0, and the first contention after reset grants requester 0.
